// File: rtl/arm_multicycle.sv
// rtl/arm_multicycle.sv - multi-cycle ARM-subset core on a unified req/ready memory port
//
// Purpose: executes AND/SUB/ADD/CMP/ORR, LDR/STR (imm12 offset) and B/BL, one state per
//   cycle, with all 16 condition codes and a persistent NZCV register. Memory outputs are
//   registered, so they are launched from the state being entered and stay put while
//   mem_ready is low.
// Optional feature: ARM_MC_BL_EN - BL also writes R14 <= instr addr + 4 in the BRANCH cycle.
// Ports:
//   clk        system clock (posedge)
//   rst        synchronous active-high reset
//   mem_req    memory request          mem_we     1 = write, 0 = read
//   mem_addr   byte address            mem_wdata  store data
//   mem_ready  completes a request     mem_rdata  read data (sampled on completion)
//   pc         current PC (debug)      flags      NZCV register {N,Z,C,V} (debug)
module arm_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [3:0]  flags
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, sd_q, sd_d;
  logic [31:0] alu_q, alu_d, addr_q, addr_d, mdr_q, mdr_d;
  logic [3:0]  flags_q, flags_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] regs_q [0:NUM_REGS-2];  // R0..R14; R15 is pc_q

  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;

  // Instruction fields
  logic [3:0]  cond, cmd, rn, rd, rm;
  logic [1:0]  op;
  logic        i_bit, s_bit, u_bit;
  assign cond  = ir_q[31:28];
  assign op    = ir_q[27:26];
  assign i_bit = ir_q[25];
  assign cmd   = ir_q[24:21];
  assign u_bit = ir_q[23];
  assign s_bit = ir_q[20];  // also the L bit of LDR/STR
  assign rn    = ir_q[19:16];
  assign rd    = ir_q[15:12];
  assign rm    = ir_q[3:0];

  logic is_dp, is_mem, is_br, dp_ok, is_cmp, mem_done;
  assign is_dp    = (op == 2'b00);
  assign is_mem   = (op == 2'b01) && !i_bit;
  assign is_br    = (op == 2'b10) && i_bit;
  assign dp_ok    = cmd inside {4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b1100};
  assign is_cmp   = (cmd == 4'b1010);
  assign mem_done = mem_req_q && mem_ready;

  // In DECODE pc_q already holds instr addr + 4, so R15 reads see instr addr + 8.
  logic [31:0] rn_val, rd_val, rm_val;
  assign rn_val = (rn == 4'd15) ? pc_q + 32'd4 : regs_q[rn];
  assign rd_val = (rd == 4'd15) ? pc_q + 32'd4 : regs_q[rd];
  assign rm_val = (rm == 4'd15) ? pc_q + 32'd4 : regs_q[rm];

  // imm8 rotated right by 2*rot4; a left shift by 32 yields zero, covering rot4 == 0.
  logic [4:0]  rot_amt;
  logic [31:0] imm_rot;
  assign rot_amt = {ir_q[11:8], 1'b0};
  assign imm_rot = ({24'd0, ir_q[7:0]} >> rot_amt) | ({24'd0, ir_q[7:0]} << (6'd32 - {1'b0, rot_amt}));

  // Condition evaluation against committed flags
  logic n_f, z_f, c_f, v_f, cond_ok;
  assign {n_f, z_f, c_f, v_f} = flags_q;
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z_f;
      4'h1: cond_ok = !z_f;
      4'h2: cond_ok = c_f;
      4'h3: cond_ok = !c_f;
      4'h4: cond_ok = n_f;
      4'h5: cond_ok = !n_f;
      4'h6: cond_ok = v_f;
      4'h7: cond_ok = !v_f;
      4'h8: cond_ok = c_f && !z_f;
      4'h9: cond_ok = !c_f || z_f;
      4'hA: cond_ok = (n_f == v_f);
      4'hB: cond_ok = (n_f != v_f);
      4'hC: cond_ok = !z_f && (n_f == v_f);
      4'hD: cond_ok = z_f || (n_f != v_f);
      4'hE: cond_ok = 1'b1;
      default: cond_ok = 1'b0;  // 1111 = never
    endcase
  end

  // ALU; C and V keep their old values for logical ops
  logic [32:0] sum;
  logic [31:0] alu_res;
  logic        alu_c, alu_v;
  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    alu_res = sum[31:0];
    alu_c   = c_f;
    alu_v   = v_f;
    case (cmd)
      4'b0000: alu_res = a_q & b_q;
      4'b1100: alu_res = a_q | b_q;
      4'b0100: begin
        alu_c = sum[32];
        alu_v = (a_q[31] == b_q[31]) && (alu_res[31] != a_q[31]);
      end
      default: begin  // SUB / CMP: carry out of a + ~b + 1 is NOT borrow
        sum     = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
        alu_res = sum[31:0];
        alu_c   = sum[32];
        alu_v   = (a_q[31] != b_q[31]) && (alu_res[31] != a_q[31]);
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    sd_d    = sd_q;
    alu_d   = alu_q;
    addr_d  = addr_q;
    mdr_d   = mdr_q;
    flags_d = flags_q;
    rf_we   = 1'b0;
    rf_wa   = rd;
    rf_wd   = alu_q;
    case (state_q)
      S_FETCH: if (mem_done) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = rn_val;
        b_d     = i_bit ? imm_rot : rm_val;
        sd_d    = rd_val;
        state_d = S_FETCH;
        if (cond_ok) begin
          if (is_dp && dp_ok) state_d = S_EXEC;
          else if (is_mem)    state_d = S_MEMADR;
          else if (is_br)     state_d = S_BRANCH;
        end
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (s_bit || is_cmp) flags_d = {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
        state_d = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        if (rd == 4'd15) pc_d = alu_q;
        else             rf_we = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        addr_d  = u_bit ? a_q + {20'd0, ir_q[11:0]} : a_q - {20'd0, ir_q[11:0]};
        state_d = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: if (mem_done) begin
        mdr_d   = mem_rdata;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_wd = mdr_q;
        if (rd == 4'd15) pc_d = mdr_q;
        else             rf_we = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWR: if (mem_done) state_d = S_FETCH;
      S_BRANCH: begin
        pc_d = pc_q + 32'd4 + {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
`ifdef ARM_MC_BL_EN
        if (ir_q[24]) begin
          rf_we = 1'b1;
          rf_wa = 4'd14;
          rf_wd = pc_q;
        end
`endif
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Launch the request of the state being entered; a waiting state re-issues the same values.
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      S_FETCH: begin
        mem_req_d  = 1'b1;
        mem_addr_d = pc_d;
      end
      S_MEMRD: begin
        mem_req_d  = 1'b1;
        mem_addr_d = addr_d;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d;
        mem_wdata_d = sd_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sd_q        <= '0;
      alu_q       <= '0;
      addr_q      <= '0;
      mdr_q       <= '0;
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sd_q        <= sd_d;
      alu_q       <= alu_d;
      addr_q      <= addr_d;
      mdr_q       <= mdr_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (rf_we) regs_q[rf_wa] <= rf_wd;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_arm_multicycle.sv
// tb/tb_arm_multicycle.sv - directed self-checking bench for arm_multicycle
module tb_arm_multicycle;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, pc;
  logic [31:0] mem_rdata = 32'd0;
  logic [3:0]  flags;

  arm_multicycle dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc), .flags(flags)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  int          wait_n = 0, cnt = 0, cyc = 0, first_req = -1, wr_n = 0, req_len = 0, unstable = 0;
  logic [31:0] first_addr = 32'd0;
  logic        hold_v = 1'b0, hold_we = 1'b0;
  logic [31:0] hold_addr = 32'd0, hold_wdata = 32'd0;
  int          wr_cyc [0:15];
  int          wr_len [0:15];
  logic [31:0] wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          n_chk = 0, n_bad = 0;
  logic        found;

  // Memory model: completes writes and logs them at the clock edge
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0; hold_v = 1'b0; req_len = 0;
    end else begin
      if (mem_req && first_req < 0) begin
        first_req  = cyc;
        first_addr = mem_addr;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          if (wr_n < 16) begin
            wr_cyc[wr_n] = cyc; wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata; wr_len[wr_n] = req_len;
          end
          wr_n++;
        end
        cnt = 0; hold_v = 1'b0; req_len = 0;
      end else if (mem_req) begin
        cnt++;
      end
      cyc++;
    end
  end

  // Drives ready/rdata away from the active edge and watches request stability
  always @(negedge clk) begin
    if (mem_req === 1'b1 && !rst) begin
      if (!hold_v) begin
        hold_v = 1'b1; hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
      end else if (mem_addr !== hold_addr || mem_we !== hold_we || (mem_we && mem_wdata !== hold_wdata)) begin
        unstable++;
      end
      req_len++;
    end
    mem_ready = (mem_req === 1'b1) && (cnt >= wait_n);
    mem_rdata = mem[mem_addr[7:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d);
    mem[a[7:2]] = d;
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem[a[7:2]];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cyc = 0; first_req = -1; wr_n = 0; unstable = 0;
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset values, first fetch, ADD R1,R0,#5 timing, STR R1 -> 0x80
    wait_n = 0; clear_mem();
    put(32'h00, 32'hE2801005); put(32'h04, 32'hE5801080); put(32'h08, 32'hEAFFFFFE);
    @(negedge clk); rst = 1'b1; @(negedge clk);
    check("A_rst_req", {31'd0, mem_req}, 32'd0);
    check("A_rst_we", {31'd0, mem_we}, 32'd0);
    check("A_rst_pc", pc, 32'h0);
    check("A_rst_flags", {28'd0, flags}, 32'd0);
    cyc = 0; first_req = -1; wr_n = 0; unstable = 0;
    rst = 1'b0;
    for (int i = 0; i < 20 && first_req < 0; i++) @(negedge clk);
    check("A_first_req_seen", (first_req >= 0) ? 32'd1 : 32'd0, 32'd1);
    check("A_first_addr", first_addr, 32'h0);
    check("A_pc_after_fetch", pc, 32'h4);
    repeat (3) @(negedge clk);
    check("A_next_fetch_req", {31'd0, mem_req}, 32'd1);
    check("A_next_fetch_addr", mem_addr, 32'h4);
    repeat (10) @(negedge clk);
    check("A_wr_n", wr_n, 1);
    check("A_wr_addr", wr_addr[0], 32'h80);
    check("A_r1", wr_data[0], 32'd5);
    check("A_str_time", wr_cyc[0] - first_req, 7);

    // 2: SUBS -> Z,C; BNE falls through, BEQ taken
    wait_n = 0; clear_mem();
    put(32'h00, 32'hE2801005); put(32'h04, 32'hE2512005);
    put(32'h08, 32'h1A000004); put(32'h0C, 32'h0A000007);
    put(32'h10, 32'hE58010A8); put(32'h14, 32'hEAFFFFFE);
    put(32'h20, 32'hE58010A4); put(32'h24, 32'hEAFFFFFE);
    put(32'h30, 32'hE58010A0); put(32'h34, 32'hEAFFFFFE);
    do_reset();
    repeat (50) @(negedge clk);
    check("B_flags", {28'd0, flags}, 32'h6);
    check("B_beq_target", rd_mem(32'hA0), 32'd5);
    check("B_bne_not_taken", rd_mem(32'hA4), 32'd0);
    check("B_beq_not_fallthru", rd_mem(32'hA8), 32'd0);
    check("B_wr_n", wr_n, 1);
    check("B_time", wr_cyc[0] - first_req, 16);

    // 3: three wait states, STR then LDR of the same word, copy out through STR
    wait_n = 3; clear_mem();
    put(32'h00, 32'hE2800080); put(32'h04, 32'hE2811005);
    put(32'h08, 32'hE5801008); put(32'h0C, 32'hE5903008);
    put(32'h10, 32'hE5803010); put(32'h14, 32'hEAFFFFFE);
    do_reset();
    repeat (120) @(negedge clk);
    check("C_wr_n", wr_n, 2);
    check("C_str_addr", wr_addr[0], 32'h88);
    check("C_str_data", wr_data[0], 32'd5);
    check("C_str_req_len", wr_len[0], 4);
    check("C_req_stable", unstable, 0);
    check("C_str_time", wr_cyc[0] - first_req, 23);
    check("C_ldr_r3_addr", wr_addr[1], 32'h90);
    check("C_ldr_r3", wr_data[1], 32'd5);

    // 4: CMP 5,#7 then signed compares
    wait_n = 0; clear_mem();
    put(32'h00, 32'hE2801005); put(32'h04, 32'hE3510007);
    put(32'h08, 32'hBA00000C); put(32'h0C, 32'hAA00000F);
    put(32'h10, 32'hCA000012); put(32'h14, 32'hDA000015);
    put(32'h40, 32'hE58010C0); put(32'h44, 32'hEAFFFFF0);
    put(32'h50, 32'hE58010C4); put(32'h54, 32'hEAFFFFFE);
    put(32'h60, 32'hE58010C8); put(32'h64, 32'hEAFFFFFE);
    put(32'h70, 32'hE58010CC); put(32'h74, 32'hEAFFFFFE);
    do_reset();
    repeat (60) @(negedge clk);
    check("D_flags", {28'd0, flags}, 32'h8);
    check("D_blt", rd_mem(32'hC0), 32'd5);
    check("D_bge", rd_mem(32'hC4), 32'd0);
    check("D_bgt", rd_mem(32'hC8), 32'd0);
    check("D_ble", rd_mem(32'hCC), 32'd5);
    check("D_wr_n", wr_n, 2);

    // 5: rotated immediate, ORR, AND, ADDS register form, R15 read
    wait_n = 0; clear_mem();
    put(32'h00, 32'hE28014FF); put(32'h04, 32'hE381200F);
    put(32'h08, 32'hE20230FF); put(32'h0C, 32'hE0914001);
    put(32'h10, 32'hE28F5000); put(32'h14, 32'hE58020C0);
    put(32'h18, 32'hE58030C4); put(32'h1C, 32'hE58040C8);
    put(32'h20, 32'hE58050CC); put(32'h24, 32'hEAFFFFFE);
    do_reset();
    repeat (80) @(negedge clk);
    check("E_orr", rd_mem(32'hC0), 32'hFF00000F);
    check("E_and", rd_mem(32'hC4), 32'h0000000F);
    check("E_adds", rd_mem(32'hC8), 32'hFE000000);
    check("E_r15_read", rd_mem(32'hCC), 32'h00000018);
    check("E_flags", {28'd0, flags}, 32'hA);

    // 6: reset during a waiting LDR read
    wait_n = 5; clear_mem();
    put(32'h00, 32'hE5903080); put(32'h04, 32'hE5803084); put(32'h08, 32'hEAFFFFFE);
    put(32'h80, 32'h00001234);
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr === 32'h80) found = 1'b1;
    end
    check("F_memrd_seen", {31'd0, found}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("F_rst_req", {31'd0, mem_req}, 32'd0);
    check("F_rst_pc", pc, 32'h0);
    check("F_no_write", wr_n, 0);
    wait_n = 0;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("F_rerun_ldr", rd_mem(32'h84), 32'h00001234);

    // 7: never-condition NOPs then BL +8 at 0x10, R14 dumped at the target
    wait_n = 0; clear_mem();
    for (int i = 0; i < 4; i++) put(32'(i * 4), 32'hF0000000);
    put(32'h10, 32'hEB000002); put(32'h20, 32'hE580E0D0); put(32'h24, 32'hEAFFFFFE);
    do_reset();
    repeat (40) @(negedge clk);
    check("G_wr_n", wr_n, 1);
    check("G_target_reached", wr_addr[0], 32'hD0);
`ifdef ARM_MC_BL_EN
    check("G_r14", wr_data[0], 32'h14);
`else
    check("G_r14", wr_data[0], 32'h0);
`endif
    check("G_time", wr_cyc[0] - first_req, 14);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
